cv32e40p_log_arbiter: RTL
=========================

CV32E40P_LOG_ARBITER -- requirements
Module: cv32e40p_log_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of event sources (harts/decoders), range 1..16.
REQ-002 SHALL have parameter CNT_W, default 16, width of the dropped-event counter.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, reset; synchronous and active-low, sampled on the clk_i rising edge.
REQ-005 SHALL have port ev_valid_i, input, NUM_SRC, per-source event strobe: illegal instruction decoded this cycle.
REQ-006 SHALL have port ev_pc_i, input, NUM_SRC x 32, per-source PC qualified by ev_valid_i.
REQ-007 SHALL have port log_valid_o, input/output direction output, 1, a log record is presented.
REQ-008 SHALL have port log_ready_i, input, 1, the sink accepts the record.
REQ-009 SHALL have port log_src_o, output, 4, source index of the presented record.
REQ-010 SHALL have port log_pc_o, output, 32, PC of the presented record.
REQ-011 SHALL have port drop_cnt_o, output, CNT_W, count of dropped events.

Function
REQ-012 SHALL never back-pressure sources; there is no ready toward sources.
REQ-013 SHALL hold one capture slot per source (valid bit plus 32-bit PC).
REQ-014 SHALL load slot s on the edge after ev_valid_i[s]=1 if the slot is empty or is drained in that same cycle.
REQ-015 SHALL drop the event if slot s is full and not drained that cycle; the slot keeps its older PC.
REQ-016 SHALL contain an output register (log_valid_o/src/pc) that is loadable when empty or when log_valid_o && log_ready_i.
REQ-017 SHALL select a slot for a loadable output register round-robin.
  - Search starts at rr_ptr, ascending with wrap-around.
  - The first full slot wins.
REQ-018 SHALL, after a grant to slot g, set rr_ptr to (g+1) mod NUM_SRC; rr_ptr SHALL be unchanged when there is no grant.
REQ-019 SHALL clear the granted slot in the grant cycle, which counts as "drained" for REQ-014.
REQ-020 SHALL have a minimum latency of 2 cycles: event at edge N, slot at N+1, log_valid_o at N+2.
REQ-021 SHALL keep log_valid_o, log_src_o and log_pc_o stable while log_valid_o && !log_ready_i.
REQ-022 SHALL sustain one record per cycle when log_ready_i is held at 1.
REQ-023 SHALL zero-extend log_src_o when NUM_SRC<16.

Reset
REQ-024 SHALL, with rst_ni=0 at an edge:
  - clear all slot valids, log_valid_o and rr_ptr;
  - set log_src_o=0, log_pc_o=0, drop_cnt_o=0.
REQ-025 SHALL discard in-flight and captured events on reset mid-operation; nothing is presented until new events arrive after rst_ni=1.

Configuration
REQ-026 SHALL, with macro CV32E40P_LOG_DROP_CNT_EN defined, increment drop_cnt_o by the number of sources dropping in a cycle.
  - The count saturates at all-ones.
REQ-027 SHALL, with CV32E40P_LOG_DROP_CNT_EN undefined, tie drop_cnt_o to 0 and instantiate no counter logic.

Structure
REQ-028 SHALL place the log record typedef (src 4 bits, pc 32 bits) and the MAX_SRC=16 constant in package cv32e40p_log_pkg.
REQ-029 SHALL implement arbitration in one sub-module, cv32e40p_log_rr_arb.
  - Inputs: request vector and rr_ptr.
  - Outputs: grant index and grant valid.

Verification
REQ-030 SHALL cover: single event src1 PC 0x0000_0100, log_ready_i=1 -> log_valid_o at +2 cycles, src=1, pc=0x100, for exactly one cycle.
REQ-031 SHALL cover: all 4 sources fire in one cycle, ready=1, rr_ptr=0 -> records src 0,1,2,3 on consecutive cycles; drop_cnt_o=0.
REQ-032 SHALL cover: ready=0, src2 fires twice (PCs 0x200, 0x204) -> output holds 0x200; slot holds 0x204; a third event 0x208 is dropped; drop_cnt_o=1 (macro on) or 0 (macro off).
REQ-033 SHALL cover: src0 slot granted in the same cycle src0 fires PC 0x300 -> no drop; 0x300 is presented next.
REQ-034 SHALL cover: drop counter preset near saturation, CNT_W=4 -> after 20 drops drop_cnt_o=0xF.
REQ-035 SHALL cover: rst_ni=0 for one edge while 3 slots are full and log_valid_o=1 -> all outputs 0 next cycle; no stale record afterwards.

Source files
------------

// File: rtl/cv32e40p_log_pkg.sv
// Shared types for the illegal-instruction log arbiter: record layout and source-index limits.
package cv32e40p_log_pkg;

   localparam int unsigned MAX_SRC = 16;
   localparam int unsigned SRC_W   = 4;

   typedef logic [SRC_W-1:0] src_idx_t;

   typedef struct packed {
      src_idx_t    src;
      logic [31:0] pc;
   } log_rec_t;

endpackage

// File: rtl/cv32e40p_log_arbiter_if.sv
// Log record channel from the arbiter to its sink (valid/ready handshake).
interface cv32e40p_log_arbiter_if;
   import cv32e40p_log_pkg::*;

   logic        log_valid_o;
   logic        log_ready_i;
   src_idx_t    log_src_o;
   logic [31:0] log_pc_o;

   modport master (output log_valid_o, output log_src_o, output log_pc_o, input log_ready_i);
   modport slave  (input log_valid_o, input log_src_o, input log_pc_o, output log_ready_i);

endinterface

// File: rtl/cv32e40p_log_rr_arb.sv
// Round-robin pick: first set request at or after rr_ptr_i, ascending with wrap-around.
module cv32e40p_log_rr_arb
   import cv32e40p_log_pkg::*;
#(
   parameter int unsigned NUM_SRC = 4
) (
   input  logic [NUM_SRC-1:0] req_i,
   input  src_idx_t           rr_ptr_i,
   output src_idx_t           gnt_idx_o,
   output logic               gnt_valid_o
);

   localparam int unsigned IdxW = SRC_W + 1;

   logic [MAX_SRC-1:0] req_ext;
   logic [IdxW-1:0]    idx;

   assign req_ext = MAX_SRC'(req_i);

   always_comb begin
      gnt_valid_o = 1'b0;
      gnt_idx_o   = '0;
      idx         = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         // rr_ptr_i < NUM_SRC, so one conditional subtract is enough for the wrap
         idx = {1'b0, rr_ptr_i} + IdxW'(i);
         if (idx >= IdxW'(NUM_SRC)) idx = idx - IdxW'(NUM_SRC);
         if (!gnt_valid_o && req_ext[idx[SRC_W-1:0]]) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = idx[SRC_W-1:0];
         end
      end
   end

endmodule

// File: rtl/cv32e40p_log_arbiter.sv
// Collects per-source illegal-instruction events into one-deep slots and serialises them
// round-robin onto a registered log channel. Define CV32E40P_LOG_DROP_CNT_EN for the drop counter.
module cv32e40p_log_arbiter
   import cv32e40p_log_pkg::*;
#(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NUM_SRC-1:0]        ev_valid_i,
   input  logic [NUM_SRC-1:0][31:0]  ev_pc_i,
   cv32e40p_log_arbiter_if.master    log,
   output logic [CNT_W-1:0]          drop_cnt_o
);

   logic [NUM_SRC-1:0] slot_valid_q, slot_valid_d;
   logic [31:0]        slot_pc_q [NUM_SRC];
   logic [31:0]        slot_pc_d [NUM_SRC];
   logic               out_valid_q, out_valid_d;
   log_rec_t           out_q, out_d;
   src_idx_t           rr_ptr_q, rr_ptr_d;

   src_idx_t           gnt_idx;
   logic               gnt_valid;
   logic               out_load;
   logic               grant;
   logic [NUM_SRC-1:0] drained;
   logic [31:0]        gnt_pc;

   cv32e40p_log_rr_arb #(
      .NUM_SRC (NUM_SRC)
   ) u_rr_arb (
      .req_i       (slot_valid_q),
      .rr_ptr_i    (rr_ptr_q),
      .gnt_idx_o   (gnt_idx),
      .gnt_valid_o (gnt_valid)
   );

   always_comb begin
      out_load = !out_valid_q || log.log_ready_i;
      grant    = out_load && gnt_valid;
      drained  = '0;
      gnt_pc   = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         if (gnt_idx == src_idx_t'(s)) begin
            drained[s] = grant;
            gnt_pc     = slot_pc_q[s];
         end
      end

      // A slot freed by this cycle's grant can take a new event in the same cycle
      for (int s = 0; s < NUM_SRC; s++) begin
         slot_valid_d[s] = slot_valid_q[s] && !drained[s];
         slot_pc_d[s]    = slot_pc_q[s];
         if (ev_valid_i[s] && (!slot_valid_q[s] || drained[s])) begin
            slot_valid_d[s] = 1'b1;
            slot_pc_d[s]    = ev_pc_i[s];
         end
      end

      out_valid_d = out_valid_q;
      out_d       = out_q;
      rr_ptr_d    = rr_ptr_q;
      if (out_load) out_valid_d = gnt_valid;
      if (grant) begin
         out_d.src = gnt_idx;
         out_d.pc  = gnt_pc;
         rr_ptr_d  = (gnt_idx == src_idx_t'(NUM_SRC - 1)) ? '0 : gnt_idx + src_idx_t'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         slot_valid_q <= '0;
         out_valid_q  <= 1'b0;
         out_q        <= '0;
         rr_ptr_q     <= '0;
      end else begin
         slot_valid_q <= slot_valid_d;
         out_valid_q  <= out_valid_d;
         out_q        <= out_d;
         rr_ptr_q     <= rr_ptr_d;
      end
   end

   // PCs are qualified by the slot valid bits, so they need no reset
   always_ff @(posedge clk_i) begin
      slot_pc_q <= slot_pc_d;
   end

   assign log.log_valid_o = out_valid_q;
   assign log.log_src_o   = out_q.src;
   assign log.log_pc_o    = out_q.pc;

`ifdef CV32E40P_LOG_DROP_CNT_EN
   localparam int unsigned SumW = CNT_W + 5;

   logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
   logic [NUM_SRC-1:0] drop;
   logic [4:0]         drop_num;
   logic [SumW-1:0]    drop_sum;

   always_comb begin
      drop_num = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         drop[s]  = ev_valid_i[s] && slot_valid_q[s] && !drained[s];
         drop_num = drop_num + {4'b0, drop[s]};
      end
      drop_sum   = SumW'(drop_cnt_q) + SumW'(drop_num);
      drop_cnt_d = (drop_sum > SumW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) drop_cnt_q <= '0;
      else         drop_cnt_q <= drop_cnt_d;
   end

   assign drop_cnt_o = drop_cnt_q;
`else
   assign drop_cnt_o = '0;
`endif

endmodule
